// File: rtl/uart_reg_responder.sv
// ---------------------------------------------------------------------------
// uart_reg_responder
//
// Host-facing responder for a small byte protocol carried over a UART. The
// host can write or read a bank of 8-bit registers:
//    write frame : 'W' (0x57), addr, data   -> answers 'K' (0x4B) or 'E' (0x45)
//    read frame  : 'R' (0x52), addr         -> answers register value or 'E'
// Any unknown command byte is answered with 'E'. Every answer is one byte
// handed to the UART transmitter with a one-cycle send pulse. The block then
// waits for the transmitter's tx_done before it accepts the next command.
//
// Ports
//    clk      : single clock, all state changes on its rising edge
//    reset    : asynchronous, active-low reset
//    rx_done  : one-cycle pulse, rx_data holds a received byte
//    rx_data  : received byte
//    tx_done  : one-cycle pulse, transmitter finished the stop bit
//    send     : one-cycle pulse, start transmitting tx_data
//    tx_data  : response byte, stable from send until tx_done
//    reg_out  : flattened register file, register i at [8i+7:8i]
//    busy     : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_reg_responder #(
   parameter int NUM_REGS = 8,
   parameter int TIMEOUT  = 1_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_done,
   input  logic [7:0]            rx_data,
   input  logic                  tx_done,
   output logic                  send,
   output logic [7:0]            tx_data,
   output logic [8*NUM_REGS-1:0] reg_out,
   output logic                  busy
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h45;

   typedef enum logic [1:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      WAIT_TX
   } state_t;

   state_t               state_q, state_nxt;
   logic                 is_write_q, is_write_nxt;
   logic [7:0]           addr_q, addr_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;
   logic                 load_tx;
   logic [7:0]           tx_nxt;
   logic                 wr_en;
   logic [7:0]           rd_val;
   logic [8*NUM_REGS-1:0] regs_q;

   // Full 8-bit unsigned comparison so out-of-range addresses never alias
   // onto a real register.
   function automatic logic addr_legal(input logic [7:0] a);
      return (int'({24'd0, a}) < NUM_REGS);
   endfunction

   // Read mux addressed by the incoming address byte; looping over the legal
   // indices avoids any truncation of the 8-bit address.
   always_comb begin
      rd_val = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rx_data == 8'(i)) begin
            rd_val = regs_q[8*i +: 8];
         end
      end
   end

   // Next-state and response decode. The inter-byte counter is cleared by
   // default, so any state change or accepted byte restarts it; it only
   // advances while waiting for a byte inside a frame. A byte arriving in the
   // same cycle as the expiry takes priority over the timeout.
   always_comb begin
      state_nxt    = state_q;
      is_write_nxt = is_write_q;
      addr_nxt     = addr_q;
      cnt_nxt      = '0;
      load_tx      = 1'b0;
      tx_nxt       = 8'h00;
      wr_en        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rx_done) begin
               if (rx_data == CMD_WRITE) begin
                  is_write_nxt = 1'b1;
                  state_nxt    = GET_ADDR;
               end else if (rx_data == CMD_READ) begin
                  is_write_nxt = 1'b0;
                  state_nxt    = GET_ADDR;
               end else begin
                  load_tx   = 1'b1;
                  tx_nxt    = RSP_ERR;
                  state_nxt = WAIT_TX;
               end
            end
         end

         GET_ADDR: begin
            if (rx_done) begin
               addr_nxt = rx_data;
               if (is_write_q) begin
                  state_nxt = GET_DATA;
               end else begin
                  load_tx   = 1'b1;
                  tx_nxt    = addr_legal(rx_data) ? rd_val : RSP_ERR;
                  state_nxt = WAIT_TX;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
         end

         GET_DATA: begin
            if (rx_done) begin
               load_tx   = 1'b1;
               state_nxt = WAIT_TX;
               if (addr_legal(addr_q)) begin
                  wr_en  = 1'b1;
                  tx_nxt = RSP_OK;
               end else begin
                  tx_nxt = RSP_ERR;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
         end

         WAIT_TX: begin
            if (tx_done) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, frame context, counter and the transmit handshake. tx_data only
   // loads together with send, so it stays stable through WAIT_TX.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         is_write_q <= 1'b0;
         addr_q     <= 8'h00;
         cnt_q      <= '0;
         send       <= 1'b0;
         tx_data    <= 8'h00;
      end else begin
         state_q    <= state_nxt;
         is_write_q <= is_write_nxt;
         addr_q     <= addr_nxt;
         cnt_q      <= cnt_nxt;
         send       <= load_tx;
         if (load_tx) begin
            tx_data <= tx_nxt;
         end
      end
   end

   // Register bank; the write lands on the same edge that sends 'K'.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (addr_q == 8'(i))) begin
               regs_q[8*i +: 8] <= rx_data;
            end
         end
      end
   end

   assign reg_out = regs_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_reg_responder
//
// Directed bench for uart_reg_responder (NUM_REGS=8, TIMEOUT=100). Stimulus
// tasks push the expected response byte into a queue before the final byte of
// a frame; an independent monitor pops and compares on every send pulse, and
// flags any send that nothing asked for.
// ---------------------------------------------------------------------------
module tb_uart_reg_responder;

   localparam int NUM_REGS = 8;
   localparam int TIMEOUT  = 100;

   logic                  clk;
   logic                  reset;
   logic                  rx_done;
   logic [7:0]            rx_data;
   logic                  tx_done;
   logic                  send;
   logic [7:0]            tx_data;
   logic [8*NUM_REGS-1:0] reg_out;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]            exp_q[$];
   logic [8*NUM_REGS-1:0] exp_regs;

   uart_reg_responder #(
      .NUM_REGS (NUM_REGS),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rx_done (rx_done),
      .rx_data (rx_data),
      .tx_done (tx_done),
      .send    (send),
      .tx_data (tx_data),
      .reg_out (reg_out),
      .busy    (busy)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Generic comparison used by both the stimulus thread and the monitor.
   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every send pulse must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (send !== 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_send: got send=%b tx_data=0x%0h expected no send",
                        send, tx_data);
            end else begin
               check_output("resp_byte", 64'(tx_data), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   // Drives one byte for one cycle; called at a falling edge, returns at the
   // next falling edge, so the byte is sampled on the rising edge between.
   task automatic apply_stimulus(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   // Final byte of a frame: queue the answer, check send is high exactly in
   // the cycle after the sampling edge and low again one cycle later.
   task automatic final_byte(input logic [7:0] b, input logic [7:0] exp);
      exp_q.push_back(exp);
      apply_stimulus(b);
      check_output("send_high", 64'(send), 64'd1);
      check_output("tx_data_now", 64'(tx_data), 64'(exp));
      @(negedge clk);
      check_output("send_one_cycle", 64'(send), 64'd0);
   endtask

   // Ends WAIT_TX: confirm the answer was consumed, tx_data still held, then
   // pulse tx_done and expect the block idle again.
   task automatic complete_tx(input logic [7:0] exp);
      int n = 0;
      while (exp_q.size() != 0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check_output("resp_drained", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      check_output("busy_wait_tx", 64'(busy), 64'd1);
      check_output("tx_data_held", 64'(tx_data), 64'(exp));
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check_output("idle_after_tx_done", 64'(busy), 64'd0);
   endtask

   task automatic check_regs(input string name);
      check_output(name, 64'(reg_out), 64'(exp_regs));
   endtask

   initial begin
      reset    = 1'b0;
      rx_done  = 1'b0;
      rx_data  = 8'h00;
      tx_done  = 1'b0;
      exp_regs = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      check_output("rst_send", 64'(send), 64'd0);
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_tx_data", 64'(tx_data), 64'd0);
      check_regs("rst_regs");
      reset = 1'b1;
      @(negedge clk);

      // Write then read register 3.
      apply_stimulus(8'h57);
      apply_stimulus(8'h03);
      final_byte(8'hA5, 8'h4B);
      exp_regs[31:24] = 8'hA5;
      check_regs("write_reg3");
      complete_tx(8'h4B);
      apply_stimulus(8'h52);
      final_byte(8'h03, 8'hA5);
      complete_tx(8'hA5);

      // Unknown command and out-of-range read.
      final_byte(8'h41, 8'h45);
      check_regs("bad_cmd_regs");
      complete_tx(8'h45);
      apply_stimulus(8'h52);
      final_byte(8'h08, 8'h45);
      complete_tx(8'h45);
      apply_stimulus(8'h52);
      final_byte(8'hFF, 8'h45);
      complete_tx(8'h45);

      // Out-of-range write: answer only after the data byte, nothing written.
      apply_stimulus(8'h57);
      apply_stimulus(8'h09);
      check_output("bad_wr_busy", 64'(busy), 64'd1);
      final_byte(8'h11, 8'h45);
      check_regs("bad_wr_regs");
      complete_tx(8'h45);
      apply_stimulus(8'h57);
      apply_stimulus(8'h05);
      final_byte(8'h3C, 8'h4B);
      exp_regs[47:40] = 8'h3C;
      check_regs("write_reg5");
      complete_tx(8'h4B);

      // Highest legal address.
      apply_stimulus(8'h57);
      apply_stimulus(8'h07);
      final_byte(8'hFF, 8'h4B);
      exp_regs[63:56] = 8'hFF;
      check_regs("write_reg7");
      complete_tx(8'h4B);
      apply_stimulus(8'h52);
      final_byte(8'h07, 8'hFF);
      complete_tx(8'hFF);

      // Timeout: 100 silent cycles after the command abandon the frame.
      apply_stimulus(8'h57);
      repeat (TIMEOUT - 1) @(negedge clk);
      check_output("busy_before_timeout", 64'(busy), 64'd1);
      @(negedge clk);
      check_output("busy_after_timeout", 64'(busy), 64'd0);
      check_regs("timeout_regs");
      apply_stimulus(8'h52);
      final_byte(8'h00, 8'h00);
      complete_tx(8'h00);

      // A byte in the last cycle before expiry wins over the timeout.
      apply_stimulus(8'h57);
      repeat (TIMEOUT - 1) @(negedge clk);
      apply_stimulus(8'h01);
      check_output("byte_beats_timeout", 64'(busy), 64'd1);
      final_byte(8'h66, 8'h4B);
      exp_regs[15:8] = 8'h66;
      check_regs("write_reg1_late");
      complete_tx(8'h4B);

      // Bytes arriving during WAIT_TX are dropped.
      apply_stimulus(8'h52);
      final_byte(8'h03, 8'hA5);
      apply_stimulus(8'h57);
      @(negedge clk);
      apply_stimulus(8'h41);
      apply_stimulus(8'h52);
      check_regs("dropped_regs");
      complete_tx(8'hA5);
      apply_stimulus(8'h52);
      final_byte(8'h05, 8'h3C);
      complete_tx(8'h3C);

      // Reset in the middle of a write frame.
      apply_stimulus(8'h57);
      apply_stimulus(8'h02);
      final_byte(8'h77, 8'h4B);
      exp_regs[23:16] = 8'h77;
      complete_tx(8'h4B);
      apply_stimulus(8'h57);
      apply_stimulus(8'h02);
      check_output("busy_mid_frame", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      exp_regs = '0;
      check_output("async_rst_busy", 64'(busy), 64'd0);
      check_output("async_rst_send", 64'(send), 64'd0);
      check_output("async_rst_tx_data", 64'(tx_data), 64'd0);
      check_regs("async_rst_regs");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      apply_stimulus(8'h52);
      final_byte(8'h02, 8'h00);
      complete_tx(8'h00);

      repeat (4) @(negedge clk);
      check_output("queue_empty_end", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_reg_responder.md
UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

Interface
REQ-001 Parameter: NUM_REGS, 8, number of 8-bit registers; legal addresses are 0..NUM_REGS-1, with NUM_REGS no greater than 256.
REQ-002 Parameter: TIMEOUT, 1_000_000, maximum inter-byte gap in clk cycles within a frame (10 ms at 100 MHz).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_done  input  1  one-cycle pulse marking a received byte valid.
REQ-006 rx_data  input  8  received byte; valid only while rx_done=1.
REQ-007 tx_done  input  1  one-cycle pulse from the UART transmitter when the stop bit is complete.
REQ-008 send  output  1  one-cycle pulse that starts transmission of tx_data.
REQ-009 tx_data  output  8  response byte; held stable from send until tx_done.
REQ-010 reg_out  output  8*NUM_REGS  flattened register file; register i is at bits [8i+7:8i].
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL be the host-facing responder of a byte protocol. Frame formats:
  - Write: 'W' (0x57), addr, data.
  - Read: 'R' (0x52), addr.
REQ-013 The FSM SHALL have exactly these states: IDLE, GET_ADDR, GET_DATA, WAIT_TX.
REQ-014 In IDLE, a byte is accepted on rx_done, with the following transitions:
  - 0x57 -> GET_ADDR (write frame).
  - 0x52 -> GET_ADDR (read frame).
  - Any other byte -> respond 'E' (0x45).
REQ-015 In GET_ADDR, on rx_done the address byte SHALL be latched:
  - Write frame -> GET_DATA.
  - Read frame with a legal address -> respond with the register value.
  - Read frame with an illegal address -> respond 'E'.
REQ-016 In GET_DATA, on rx_done:
  - Legal address -> write the register and respond 'K' (0x4B).
  - Illegal address -> respond 'E' and leave all registers unchanged. The data byte is still consumed so framing stays aligned.
REQ-017 "Respond X" SHALL mean, on the same clock edge that samples the final rx_done:
  - tx_data <= X, send <= 1, state <= WAIT_TX.
  - Any register write also completes on that edge.
  - On the next edge send <= 0, so send is high for exactly one cycle, one cycle after the final rx_done.
REQ-018 A read response SHALL carry the register value as it stands at the sampling edge.
REQ-019 In WAIT_TX the block SHALL return to IDLE on the first tx_done pulse; tx_done in any other state SHALL be ignored.
REQ-020 rx_done pulses arriving during WAIT_TX SHALL be dropped, with no state or register effect.
REQ-021 Inter-byte timeout in GET_ADDR and GET_DATA:
  - A counter SHALL clear on entry to the state and on every accepted byte, and increment every other cycle.
  - When it reaches TIMEOUT-1 the FSM SHALL return to IDLE with no response and no register write.
REQ-022 If rx_done and the timeout expiry occur in the same cycle, the byte SHALL win and the timeout is not taken.
REQ-023 The timeout SHALL NOT apply in WAIT_TX.
REQ-024 The counter SHALL be ceil(log2(TIMEOUT)) bits wide and SHALL saturate rather than wrap.
REQ-025 Addresses SHALL be compared as a full 8-bit unsigned value; no truncation or aliasing is permitted (e.g. 0x08 is illegal when NUM_REGS=8).
REQ-026 reg_out SHALL be driven directly from the registers with no output latency; a write is visible the cycle after its sampling edge.

Reset
REQ-027 While reset=0 the block SHALL immediately (asynchronously) force:
  - state = IDLE;
  - send = 0, tx_data = 0x00, busy = 0;
  - all registers = 0x00;
  - timeout counter = 0.
REQ-028 Reset asserted mid-frame or in WAIT_TX SHALL abandon the frame with no further send pulse.
REQ-029 After reset deasserts, the first rx_done SHALL be treated as a command byte.

Verification
REQ-030 Write then read: rx 0x57,0x03,0xA5, then tx_done -> exactly one send with tx_data=0x4B; reg_out[31:24]=0xA5. Then rx 0x52,0x03 -> send with tx_data=0xA5.
REQ-031 Bad command and bad read address:
  - rx 0x41 -> send one cycle later with tx_data=0x45; registers unchanged.
  - rx 0x52,0x08 -> tx_data=0x45.
REQ-032 Bad write address: rx 0x57,0x09,0x11 -> tx_data=0x45 after the third byte only; reg_out unchanged; next frame decodes normally.
REQ-033 Timeout (TIMEOUT=100 for sim): rx 0x57, then idle 100 cycles -> busy falls, no send.
  - Subsequent 0x52,0x00 -> returns 0x00.
  - A byte arriving exactly at cycle 99 -> accepted, no timeout taken.
REQ-034 Dropped bytes: rx_done pulses during WAIT_TX -> no effect; after tx_done the next byte is decoded as a command.
REQ-035 Reset mid-frame: reset=0 after 0x57,0x02 -> outputs clear at once; after release, rx 0x52,0x02 -> tx_data=0x00.
